// File: rtl/bin_seq_checker_if.sv
// Bus between a binary sequence counter and its checker.
//   cnt_en    : sample strobe, count_in valid when high
//   count_in  : count bus from the counter under check
//   clr_err   : synchronous clear of err_count
//   locked    : sequence lock established
//   err_pulse : one-cycle pulse per sequence error while locked
//   err_count : saturating error count
//   expected  : value predicted for the next sample
// master drives the counter side, slave is the checker.
interface bin_seq_checker_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 8
);
  logic             cnt_en;
  logic [WIDTH-1:0] count_in;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

  modport master (
    output cnt_en, count_in, clr_err,
    input  locked, err_pulse, err_count, expected
  );

  modport slave (
    input  cnt_en, count_in, clr_err,
    output locked, err_pulse, err_count, expected
  );
endinterface

// File: rtl/bin_seq_checker.sv
// Receive-side monitor for a binary wrap-around counter MIN_VAL..MAX_VAL.
// Hunts for an in-range sample, confirms LOCK_COUNT consecutive correct
// transitions, then flags and counts every sample that breaks the sequence.
// Ports:
//   clk   : rising-edge clock
//   rstb  : asynchronous active-low reset
//   bus   : slave side of bin_seq_checker_if (strobe, count, clear in;
//           locked, err_pulse, err_count, expected out, all registered)
module bin_seq_checker #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned MIN_VAL      = 0,
  parameter int unsigned MAX_VAL      = 15,
  parameter int unsigned LOCK_COUNT   = 3,
  parameter int unsigned UNLOCK_COUNT = 2,
  parameter int unsigned ERR_W        = 8
) (
  input  logic            clk,
  input  logic            rstb,
  bin_seq_checker_if.slave bus
);

  localparam int unsigned MC_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned XC_W = $clog2(UNLOCK_COUNT + 1);

  localparam logic [WIDTH-1:0] MIN_V     = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_VAL);
  localparam logic [MC_W-1:0]  MATCH_END = MC_W'(LOCK_COUNT - 1);
  localparam logic [XC_W-1:0]  MISS_END  = XC_W'(UNLOCK_COUNT - 1);
  localparam logic [ERR_W-1:0] ERR_SAT   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] expected_q;
  logic [MC_W-1:0]  match_cnt;
  logic [XC_W-1:0]  miss_cnt;
  logic             locked_q;
  logic             err_pulse_q;
  logic [ERR_W-1:0] err_count_q;

  // Successor in the wrap-around sequence.
  function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] x);
    return (x == MAX_V) ? MIN_V : x + WIDTH'(1);
  endfunction

  // Range check via borrow bits, so a MIN_VAL of zero does not produce a
  // constant comparison.
  logic [WIDTH:0] below_diff_c;
  logic [WIDTH:0] above_diff_c;
  logic           in_range_c;
  logic           match_c;
  logic           err_hit_c;

  assign below_diff_c = {1'b0, bus.count_in} - {1'b0, MIN_V};
  assign above_diff_c = {1'b0, MAX_V} - {1'b0, bus.count_in};
  assign in_range_c   = ~below_diff_c[WIDTH] & ~above_diff_c[WIDTH];
  assign match_c      = (bus.count_in == expected_q);
  assign err_hit_c    = bus.cnt_en && (state == LOCKED) && !match_c;

  // Sequence tracker: state only advances on sampling edges.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= HUNT;
      expected_q <= MIN_V;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      locked_q   <= 1'b0;
    end else if (bus.cnt_en) begin
      case (state)
        HUNT: begin
          if (in_range_c) begin
            expected_q <= next_val(bus.count_in);
            match_cnt  <= '0;
            state      <= SYNC;
          end
        end

        SYNC: begin
          if (match_c) begin
            expected_q <= next_val(bus.count_in);
            if (match_cnt == MATCH_END) begin
              match_cnt <= '0;
              miss_cnt  <= '0;
              locked_q  <= 1'b1;
              state     <= LOCKED;
            end else begin
              match_cnt <= match_cnt + MC_W'(1);
            end
          end else if (in_range_c) begin
            // Silent re-seed: errors only count once locked.
            expected_q <= next_val(bus.count_in);
            match_cnt  <= '0;
          end else begin
            match_cnt <= '0;
            state     <= HUNT;
          end
        end

        LOCKED: begin
          if (match_c) begin
            expected_q <= next_val(expected_q);
            miss_cnt   <= '0;
          end else if (miss_cnt == MISS_END) begin
            locked_q  <= 1'b0;
            miss_cnt  <= '0;
            match_cnt <= '0;
            if (in_range_c) begin
              expected_q <= next_val(bus.count_in);
              state      <= SYNC;
            end else begin
              expected_q <= next_val(expected_q);
              state      <= HUNT;
            end
          end else begin
            // Flywheel the prediction through isolated glitches.
            expected_q <= next_val(expected_q);
            miss_cnt   <= miss_cnt + XC_W'(1);
          end
        end

        default: begin
          state    <= HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // Error pulse and saturating counter; a clear still counts a coincident error.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= err_hit_c;
      if (bus.clr_err) begin
        err_count_q <= err_hit_c ? ERR_W'(1) : '0;
      end else if (err_hit_c && (err_count_q != ERR_SAT)) begin
        err_count_q <= err_count_q + ERR_W'(1);
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.expected  = expected_q;

endmodule

// File: tb/tb_bin_seq_checker.sv
// Directed bench for bin_seq_checker with WIDTH=4, range 0..15, lock after 3,
// unlock after 2 misses, 8-bit error counter.
module tb_bin_seq_checker;

  logic clk;
  logic rstb;
  int   n_checks;
  int   n_pass;

  bin_seq_checker_if #(.WIDTH(4), .ERR_W(8)) bus ();

  bin_seq_checker #(
    .WIDTH(4), .MIN_VAL(0), .MAX_VAL(15),
    .LOCK_COUNT(3), .UNLOCK_COUNT(2), .ERR_W(8)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // Drive at the falling edge, return 1 time unit after the following rising edge.
  task automatic step(input logic en, input logic [3:0] v, input logic clr);
    @(negedge clk);
    bus.cnt_en   = en;
    bus.count_in = v;
    bus.clr_err  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [3:0] v);
    step(1'b1, v, 1'b0);
  endtask

  function automatic logic [3:0] nxt(input logic [3:0] x);
    return (x == 4'd15) ? 4'd0 : x + 4'd1;
  endfunction

  logic [3:0] e;

  initial begin
    clk = 1'b0;
    rstb = 1'b0;
    n_checks = 0;
    n_pass = 0;
    bus.cnt_en = 1'b0;
    bus.count_in = 4'd0;
    bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_pulse", 32'(bus.err_pulse), 0);
    check("rst_errcnt", 32'(bus.err_count), 0);
    check("rst_expected", 32'(bus.expected), 0);
    @(negedge clk);
    rstb = 1'b1;

    // 1: acquire lock on 0,1,2,3
    feed(4'd0);
    check("t1_s0_locked", 32'(bus.locked), 0);
    check("t1_s0_expected", 32'(bus.expected), 1);
    feed(4'd1);
    feed(4'd2);
    check("t1_s2_locked", 32'(bus.locked), 0);
    feed(4'd3);
    check("t1_locked", 32'(bus.locked), 1);
    check("t1_expected", 32'(bus.expected), 4);
    check("t1_errcnt", 32'(bus.err_count), 0);

    // 2: run to 13, then wrap 14,15,0,1
    for (int v = 4; v <= 13; v++) begin
      feed(4'(v));
      check($sformatf("t2_run%0d_pulse", v), 32'(bus.err_pulse), 0);
    end
    feed(4'd14);
    feed(4'd15);
    check("t2_15_pulse", 32'(bus.err_pulse), 0);
    feed(4'd0);
    check("t2_wrap_pulse", 32'(bus.err_pulse), 0);
    feed(4'd1);
    check("t2_expected", 32'(bus.expected), 2);
    check("t2_errcnt", 32'(bus.err_count), 0);
    check("t2_locked", 32'(bus.locked), 1);

    // 3: expected=6, feed 9 then 7
    for (int v = 2; v <= 5; v++) feed(4'(v));
    check("t3_pre_expected", 32'(bus.expected), 6);
    feed(4'd9);
    check("t3_err_pulse", 32'(bus.err_pulse), 1);
    check("t3_errcnt", 32'(bus.err_count), 1);
    check("t3_err_locked", 32'(bus.locked), 1);
    check("t3_flywheel", 32'(bus.expected), 7);
    feed(4'd7);
    check("t3_ok_pulse", 32'(bus.err_pulse), 0);
    check("t3_ok_expected", 32'(bus.expected), 8);
    // Miss counter must have cleared: a fresh single miss keeps lock.
    feed(4'd3);
    check("t3_miss_pulse", 32'(bus.err_pulse), 1);
    check("t3_miss_errcnt", 32'(bus.err_count), 2);
    check("t3_miss_locked", 32'(bus.locked), 1);
    feed(4'd9);
    check("t3_rec_expected", 32'(bus.expected), 10);

    // 4: counter resets to 0 twice -> lose lock, SYNC seeded at 1
    feed(4'd0);
    check("t4_e1_pulse", 32'(bus.err_pulse), 1);
    check("t4_e1_errcnt", 32'(bus.err_count), 3);
    check("t4_e1_locked", 32'(bus.locked), 1);
    feed(4'd0);
    check("t4_e2_pulse", 32'(bus.err_pulse), 1);
    check("t4_e2_errcnt", 32'(bus.err_count), 4);
    check("t4_e2_locked", 32'(bus.locked), 0);
    check("t4_e2_expected", 32'(bus.expected), 1);
    // From SYNC three matches re-lock; from HUNT it would take four samples.
    feed(4'd1);
    check("t4_sync_pulse", 32'(bus.err_pulse), 0);
    feed(4'd2);
    check("t4_sync_locked", 32'(bus.locked), 0);
    feed(4'd3);
    check("t4_relocked", 32'(bus.locked), 1);
    check("t4_relock_expected", 32'(bus.expected), 4);

    // 5: hold for 20 cycles with junk on the bus, then resume
    for (int i = 0; i < 20; i++) step(1'b0, 4'(i * 7), 1'b0);
    check("t5_hold_locked", 32'(bus.locked), 1);
    check("t5_hold_expected", 32'(bus.expected), 4);
    check("t5_hold_errcnt", 32'(bus.err_count), 4);
    feed(4'd4);
    feed(4'd5);
    check("t5_resume_pulse", 32'(bus.err_pulse), 0);
    check("t5_resume_expected", 32'(bus.expected), 6);
    check("t5_resume_errcnt", 32'(bus.err_count), 4);
    feed(4'd9);
    check("t5_err_pulse", 32'(bus.err_pulse), 1);
    step(1'b0, 4'd0, 1'b0);
    check("t5_idle_pulse_drop", 32'(bus.err_pulse), 0);
    check("t5_idle_errcnt", 32'(bus.err_count), 5);
    check("t5_idle_expected", 32'(bus.expected), 7);
    @(negedge clk);
    bus.cnt_en = 1'b0;
    #2 rstb = 1'b0;
    #1;
    check("t5_arst_locked", 32'(bus.locked), 0);
    check("t5_arst_pulse", 32'(bus.err_pulse), 0);
    check("t5_arst_errcnt", 32'(bus.err_count), 0);
    check("t5_arst_expected", 32'(bus.expected), 0);
    @(negedge clk);
    rstb = 1'b1;

    // 6: saturate the error counter, then clear on an error edge
    for (int v = 0; v <= 3; v++) feed(4'(v));
    check("t6_locked", 32'(bus.locked), 1);
    e = 4'd4;
    for (int i = 0; i < 300; i++) begin
      feed(e + 4'd8);
      if (i == 254) check("t6_reach_sat", 32'(bus.err_count), 255);
      if (i == 299) check("t6_sat_pulse", 32'(bus.err_pulse), 1);
      e = nxt(e);
      feed(e);
      e = nxt(e);
    end
    check("t6_sat_errcnt", 32'(bus.err_count), 255);
    check("t6_sat_locked", 32'(bus.locked), 1);
    check("t6_sat_expected", 32'(bus.expected), 32'(e));
    step(1'b1, e + 4'd8, 1'b1);
    e = nxt(e);
    check("t6_clr_on_err", 32'(bus.err_count), 1);
    check("t6_clr_err_pulse", 32'(bus.err_pulse), 1);
    step(1'b1, e, 1'b1);
    check("t6_clr_plain", 32'(bus.err_count), 0);
    check("t6_clr_locked", 32'(bus.locked), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
